split: RTL
==========

# split

Address-decoded 1-master-to-N-slaves bus demultiplexer for the IOb native interconnect, the counterpart of the N-to-1 merge block. It selects the target slave from the top address bits and forwards the request only to that slave. It latches the selected slave for the life of each transaction, so the response is taken only from the slave that was addressed. A decode-error path and a per-transaction timeout guarantee that the master always receives `ready`.

## Interface
- `N_SLAVES`, 2: number of slave ports, ≥2. `SEL_W = $clog2(N_SLAVES)`.
- `DATA_W`, 32: data width. `DATA_W/8` byte strobes.
- `ADDR_W`, 32: address width.
- `P_SLAVES`, `ADDR_W-1`: MSB index of the select field. Select is `addr[P_SLAVES -: SEL_W]`.
- `TIMEOUT_W`, 8: timeout counter width.
- Request layout, MSB first: `{valid, addr[ADDR_W], wdata[DATA_W], wstrb[DATA_W/8]}`, width `REQ_W`. Response layout: `{rdata[DATA_W], ready}`, width `RESP_W`. Both come from `interconnect.vh`.
- `clk`  in  1  clock. One clock domain.
- `rst`  in  1  reset. Synchronous, active-high.
- `m_req`  in  `REQ_W`  master request.
- `m_resp`  out  `RESP_W`  master response.
- `s_req`  out  `N_SLAVES*REQ_W`  slave requests. Slave i occupies `[i*REQ_W +: REQ_W]`.
- `s_resp`  in  `N_SLAVES*RESP_W`  slave responses, indexed the same way.
- `err`  out  1  one-cycle pulse on a decode error or a timeout.

## Operation
- Protocol rules:
  - The master holds `valid` and all request fields stable until it sees `ready`.
  - A slave asserts `ready` for exactly one cycle per transaction.
- FSM states: IDLE, BUSY, DECERR. A registered `sel_q` holds the selected slave. A registered `cnt` is `TIMEOUT_W` bits wide.
- IDLE:
  - `sel = addr[P_SLAVES -: SEL_W]`.
  - If `valid` and `sel < N_SLAVES`: drive `s_req[sel] = m_req` and `m_resp = s_resp[sel]`, and load `sel_q = sel`.
    - If that slave's `ready` = 1 in the same cycle, the transaction completes and the FSM stays in IDLE.
    - Otherwise go to BUSY with `cnt = 0`.
  - If `valid` and `sel ≥ N_SLAVES`: no slave sees `valid`. Go to DECERR.
- BUSY:
  - Routing uses `sel_q` only. Address changes on `m_req` are ignored.
  - `s_req[sel_q] = m_req` and `m_resp = s_resp[sel_q]`.
  - On slave `ready`: go to IDLE.
  - Otherwise `cnt++`. When `cnt == 2^TIMEOUT_W-1` and `ready` is still 0:
    - drive `m_resp = {32'hDEADBEEF truncated/zero-extended to DATA_W, 1'b1}`;
    - force the slave `valid` to 0 in that cycle;
    - pulse `err`;
    - go to IDLE.
  - A slave `ready` arriving in the same cycle as the timeout wins: it is a normal completion with no `err`.
- DECERR: drive `m_resp = {0, 1'b1}` for one cycle, pulse `err`, and go to IDLE.
- Non-selected slaves always receive an all-zero request. Their responses are ignored, even when their `ready` = 1.
- In IDLE with `valid` = 0: `s_req` = 0 and `m_resp` = 0.

## Timing
- Reset:
  - While `rst` is high, state = IDLE, `sel_q` = 0, `cnt` = 0, `err` = 0.
  - `s_req` = 0 and `m_resp` = 0 while `rst` is high. The output gating is combinational on `rst`.
  - A reset asserted mid-transaction abandons the transaction and never produces a `ready` for it.
- Latency:
  - Zero-wait slave: `m_resp.ready` in the same cycle as `valid`. The path is combinational through the IDLE decode.
  - Slave with k wait cycles: `ready` is returned k cycles after `valid`, with no added cycles.
  - Decode error: `ready` one cycle after `valid`.
  - Timeout: `ready` on the cycle where `cnt` reaches `2^TIMEOUT_W-1`.
- Back-to-back:
  - A new `valid` may be sampled in the cycle after `ready`, including after a DECERR or timeout response.
  - The FSM is in IDLE in that cycle, so zero-bubble streaming to zero-wait slaves is sustained at one transaction per cycle.
- `err` is registered: it is high in the cycle of the error `ready` and low otherwise. In DECERR and timeout cycles `err` and `m_resp.ready` are coincident.

## Test plan
- Routing (`N_SLAVES=3`, `P_SLAVES=31`): write `addr=0x4000_0010`, `wdata=0x1234_5678`, `wstrb=0xF` → only slave 1 sees `valid`, with matching fields. Slave 1 returns `ready` after 2 cycles → `m_resp.ready` after 2 cycles; slaves 0 and 2 see all zeros.
- Response isolation: read slave 2 (`addr=0x8000_0000`) while slave 0 spuriously drives `ready=1`, `rdata=0xAAAA_AAAA` → `m_resp` stays 0. Slave 2 returns `rdata=0x5555_0001` → `m_resp={0x5555_0001,1}`.
- Decode error: `addr=0xC000_0000` → no slave `valid`. Next cycle `m_resp={0,1}` and `err=1`, followed by IDLE.
- Timeout (`TIMEOUT_W=4`): slave 0 never answers → `ready` with `rdata=0xDEADBEEF` and `err=1` after 15 BUSY cycles. An immediately following read to slave 1 completes normally.
- Back-to-back: 8 consecutive reads alternating slaves 0/1, both zero-wait → 8 `ready`s in 8 cycles, each carrying the correct slave's `rdata`.
- Reset mid-BUSY: assert `rst` on cycle 3 of a wait state → `s_req`/`m_resp` are 0 while `rst` is high. After release, no stale `ready` is delivered, and a new transaction completes normally.

Source files
------------

// File: rtl/split.sv
// ---------------------------------------------------------------------------
// split -- 1-master-to-N-slaves address-decoded demultiplexer (IOb native bus)
//
// The top address bits select one slave. The request goes only to that slave,
// and the response comes only from it. The selected slave is held in sel_q
// until the transaction ends, so a master address change cannot move the
// response path mid-transaction. The master always gets a ready: an
// unmapped select returns a decode-error response, and a slave that does not
// answer in time returns a timeout response.
//
// Ports
//   clk     clock
//   rst     synchronous active-high reset; also gates s_req/m_resp/err to 0
//   m_req   master request  {valid, addr, wdata, wstrb}
//   m_resp  master response {rdata, ready}
//   s_req   slave requests, slave i at [i*REQ_W +: REQ_W]
//   s_resp  slave responses, slave i at [i*RESP_W +: RESP_W]
//   err     one-cycle pulse, coincident with a decode-error or timeout ready
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | decode m_req address; zero-wait slaves complete here
// BUSY   | waiting on slave sel_q; cnt counts wait cycles toward timeout
// DECERR | unmapped select: return {0, ready}, pulse err
// ---------------------------------------------------------------------------
module split #(
  parameter  int N_SLAVES  = 2,
  parameter  int DATA_W    = 32,
  parameter  int ADDR_W    = 32,
  parameter  int P_SLAVES  = ADDR_W - 1,
  parameter  int TIMEOUT_W = 8,
  localparam int SEL_W     = $clog2(N_SLAVES),
  localparam int REQ_W     = 1 + ADDR_W + DATA_W + DATA_W/8,
  localparam int RESP_W    = DATA_W + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [REQ_W-1:0]           m_req,
  output logic [RESP_W-1:0]          m_resp,
  output logic [N_SLAVES*REQ_W-1:0]  s_req,
  input  logic [N_SLAVES*RESP_W-1:0] s_resp,
  output logic                       err
);

  typedef enum logic [1:0] {IDLE, BUSY, DECERR} state_t;

  localparam logic [TIMEOUT_W-1:0] CNT_MAX = '1;
  localparam logic [DATA_W-1:0]    TO_DATA = DATA_W'(32'hDEADBEEF);

  state_t               state;
  logic [SEL_W-1:0]     sel_q;
  logic [TIMEOUT_W-1:0] cnt;
  logic                 err_q;

  logic                 m_valid;
  logic [SEL_W-1:0]     dec_sel;
  logic                 dec_ok;
  logic                 route_en;
  logic [SEL_W-1:0]     route_sel;
  logic [RESP_W-1:0]    sel_resp;
  logic                 slv_ready;
  logic                 at_limit;
  logic                 timeout;

  // addr[b] sits at m_req bit (REQ_W-1-ADDR_W+b)
  assign m_valid = m_req[REQ_W-1];
  assign dec_sel = m_req[REQ_W-1-ADDR_W+P_SLAVES -: SEL_W];
  assign dec_ok  = (int'(dec_sel) < N_SLAVES);

  assign at_limit = (state == BUSY) && (cnt == CNT_MAX);

  always_comb begin
    route_en  = 1'b0;
    route_sel = '0;
    case (state)
      IDLE: begin
        route_en  = m_valid && dec_ok;
        route_sel = dec_sel;
      end
      BUSY: begin
        route_en  = 1'b1;
        route_sel = sel_q;
      end
      default: ;
    endcase
    if (rst) route_en = 1'b0;
  end

  // Only the routed slave sees the request; everyone else gets zeros.
  // At the timeout limit the slave's valid is dropped so it does not start
  // work the master will never wait for.
  always_comb begin
    s_req    = '0;
    sel_resp = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (route_en && (int'(route_sel) == i)) begin
        sel_resp                 = s_resp[i*RESP_W +: RESP_W];
        s_req[i*REQ_W +: REQ_W]  = m_req;
        if (at_limit) s_req[i*REQ_W + REQ_W - 1] = 1'b0;
      end
    end
  end

  assign slv_ready = route_en && sel_resp[0];
  // a real slave ready on the limit cycle wins over the timeout
  assign timeout   = at_limit && !slv_ready;

  always_comb begin
    m_resp = '0;
    if (rst)                  m_resp = '0;
    else if (state == DECERR) m_resp = {{DATA_W{1'b0}}, 1'b1};
    else if (timeout)         m_resp = {TO_DATA, 1'b1};
    else if (route_en)        m_resp = sel_resp;
  end

  // err_q is raised one cycle ahead so it lines up with the error ready;
  // the mask drops it if the slave answers on the timeout cycle after all.
  assign err = err_q && !slv_ready && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sel_q <= '0;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (m_valid) begin
            if (dec_ok) begin
              sel_q <= dec_sel;
              if (!slv_ready) begin
                state <= BUSY;
                cnt   <= '0;
              end
            end else begin
              state <= DECERR;
              err_q <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (slv_ready || at_limit) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_MAX - 1'b1) err_q <= 1'b1;
          end
        end
        DECERR:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
